bcd_conv_seq: RTL and testbench

Parametrised sequential binary-to-BCD converter. It uses the shift-add-3 (double-dabble) method with a start/done handshake and replaces the fixed 8-bit, 3-digit combinational converter in the display path. It accepts a DATA_W-bit unsigned value and produces DIGITS packed BCD digits after DATA_W clock cycles. It sits between arithmetic or counter logic and the seven-segment digit decoders, and flags values that do not fit in DIGITS digits.

---
 rtl/bcd_pkg.sv | 35 +++
 rtl/bcd_digit_adj.sv | 15 +
 rtl/bcd_conv_seq.sv | 126 ++++++++++++
 tb/tb_bcd_conv_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   DIGIT_W    : bits per packed BCD digit
//   ADJ_THRESH : digit value at or above which the add-3 correction applies
//   ADJ_ADD    : correction added before each shift
//   min_digits : decimal digits needed to hold any w-bit unsigned value
//   state_t    : converter FSM states
package bcd_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam logic [3:0]  ADJ_THRESH = 4'd5;
    localparam logic [3:0]  ADJ_ADD    = 4'd3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Smallest d with 10^d >= 2^w, so that 2^w-1 fits in d digits.
    function automatic int unsigned min_digits(input int unsigned w);
        longint unsigned lim;
        longint unsigned p;
        int unsigned     d;
        lim = 64'd1 << w;
        p   = 64'd10;
        d   = 1;
        for (int unsigned i = 0; i < 20; i++) begin
            if (p < lim) begin
                p = p * 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
//   i_digit : current BCD digit (0..9)
//   o_digit : corrected digit (0..4 unchanged, 5..9 -> 8..12)
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Input is at most 9, so the 4-bit sum never wraps.
    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + ADJ_ADD) : i_digit;

endmodule

// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   start    : request a conversion; ignored while busy
//   DataIn   : DATA_W-bit unsigned value, captured on the accepted start
//   busy     : conversion in progress
//   done     : one-cycle pulse when bcd/overflow are updated
//   bcd      : DIGITS packed BCD digits, digit 0 in bcd[3:0]
//   overflow : value did not fit in DIGITS digits
module bcd_conv_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DATA_W-1:0]           DataIn,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*DIGITS-1:0]   bcd,
    output logic                        overflow
);

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_bin;
    logic [BCD_W-1:0]   r_work;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_overflow;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_work_shift;
    logic               w_shift_out;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_work[g*DIGIT_W +: DIGIT_W]),
                .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // {work, bin} shifted left by one after correction; the work MSB falls out.
    assign w_work_shift = {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
    assign w_shift_out  = w_adj[BCD_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin      <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_bin  <= DataIn;
                r_work <= '0;
                r_cnt  <= '0;
                r_ovf  <= 1'b0;
            end else if (w_step) begin
                r_bin  <= r_bin << 1;
                r_work <= w_work_shift;
                r_cnt  <= r_cnt + CNT_W'(1);
                r_ovf  <= r_ovf | w_shift_out;
            end
            // Result registers see only the final shift, never partial values.
            if (w_last) begin
                r_bcd      <= w_work_shift;
                r_overflow <= r_ovf | w_shift_out;
            end
        end
    end

    assign busy     = (r_state == SHIFT);
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed self-checking bench for bcd_conv_seq: three instances
// (8b/3 digits, 8b/2 digits, 16b/min_digits(16) digits) on a shared clock.
module tb_bcd_conv_seq;
    import bcd_pkg::*;

    localparam int unsigned DIG_C = min_digits(16);

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] din;
    int          dsel;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic        busy_c, done_c, ovf_c;
    logic [4*DIG_C-1:0] bcd_c;

    logic        m_busy, m_done, m_ovf;
    logic [63:0] m_bcd;

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bcd_conv_seq #(.DATA_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst(rst), .start(start && (dsel == 0)), .DataIn(din[7:0]),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
    );

    bcd_conv_seq #(.DATA_W(8), .DIGITS(2)) u_b (
        .clk(clk), .rst(rst), .start(start && (dsel == 1)), .DataIn(din[7:0]),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
    );

    bcd_conv_seq #(.DATA_W(16), .DIGITS(DIG_C)) u_c (
        .clk(clk), .rst(rst), .start(start && (dsel == 2)), .DataIn(din),
        .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c)
    );

    always_comb begin
        m_busy = busy_a;
        m_done = done_a;
        m_ovf  = ovf_a;
        m_bcd  = 64'(bcd_a);
        case (dsel)
            1: begin m_busy = busy_b; m_done = done_b; m_ovf = ovf_b; m_bcd = 64'(bcd_b); end
            2: begin m_busy = busy_c; m_done = done_c; m_ovf = ovf_c; m_bcd = 64'(bcd_c); end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then wait (bounded) for done and check it.
    task automatic convert(input int sel, input logic [15:0] v, input int lat,
                           input logic chk_bcd, input logic [63:0] exp_bcd,
                           input logic exp_ovf, input string tag);
        int   cyc;
        logic busy_ok;
        dsel  = sel;
        din   = v;
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cyc     = 0;
        busy_ok = 1'b1;
        while (!m_done && cyc < 200) begin
            if (!m_busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(m_busy), 64'd0);
        if (chk_bcd) chk({tag, "_bcd"}, m_bcd, exp_bcd);
        chk({tag, "_ovf"}, 64'(m_ovf), 64'(exp_ovf));
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, 64'(m_done), 64'd0);
        if (chk_bcd) chk({tag, "_bcd_hold"}, m_bcd, exp_bcd);
    endtask

    initial begin
        logic [11:0] ref_bcd;
        logic        seen;
        int          cnt;

        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        dsel  = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'({busy_a, busy_b, busy_c}), 64'd0);
        chk("rst_done", 64'({done_a, done_b, done_c}), 64'd0);
        chk("rst_ovf",  64'({ovf_a, ovf_b, ovf_c}), 64'd0);
        chk("rst_bcd_a", 64'(bcd_a), 64'd0);
        chk("rst_bcd_b", 64'(bcd_b), 64'd0);
        chk("rst_bcd_c", 64'(bcd_c), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic 8-bit / 3-digit conversions
        convert(0, 16'd255, 8, 1'b1, 64'h255, 1'b0, "a255");
        convert(0, 16'd0,   8, 1'b1, 64'h000, 1'b0, "a0");
        convert(0, 16'd9,   8, 1'b1, 64'h009, 1'b0, "a9");
        convert(0, 16'd100, 8, 1'b1, 64'h100, 1'b0, "a100");

        // Exhaustive sweep against a divide/modulo reference
        for (int n = 0; n < 256; n++) begin
            ref_bcd = {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
            convert(0, 16'(n), 8, 1'b1, 64'(ref_bcd), 1'b0, "exh");
        end

        // Two-digit instance: out-of-range and boundary values
        convert(1, 16'd123, 8, 1'b0, 64'd0,  1'b1, "b123");
        convert(1, 16'd99,  8, 1'b1, 64'h99, 1'b0, "b99");
        convert(1, 16'd100, 8, 1'b0, 64'd0,  1'b1, "b100");
        convert(1, 16'd0,   8, 1'b1, 64'h00, 1'b0, "b0");

        // Abort: 200 started, start re-pulsed at cycle 3, rst at cycle 5
        dsel  = 0;
        din   = 16'd200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin start = 1'b1; din = 16'd7; end
            if (c == 3) start = 1'b0;
            if (c == 4) begin
                chk("abort_busy_before_rst", 64'(busy_a), 64'd1);
                rst = 1'b1;
            end
            @(posedge clk); #1;
            seen = seen | done_a;
        end
        rst = 1'b0;
        chk("abort_busy", 64'(busy_a), 64'd0);
        chk("abort_done", 64'(done_a), 64'd0);
        chk("abort_bcd",  64'(bcd_a), 64'd0);
        chk("abort_ovf",  64'(ovf_a), 64'd0);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            seen = seen | done_a | busy_a;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        convert(0, 16'd42, 8, 1'b1, 64'h042, 1'b0, "a42");

        // 16-bit: start held through the done cycle
        dsel  = 2;
        din   = 16'd65535;
        start = 1'b1;
        @(posedge clk); #1;
        din = 16'd1;
        cnt = 0;
        while (!done_c && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("c_first_latency", 64'(cnt), 64'd16);
        chk("c_first_bcd", 64'(bcd_c), 64'h65535);
        chk("c_first_ovf", 64'(ovf_c), 64'd0);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) begin
                start = 1'b0;
                chk("c_restart_busy", 64'(busy_c), 64'd1);
            end
            if (cnt == 5) chk("c_bcd_hold_mid", 64'(bcd_c), 64'h65535);
        end while (!done_c && cnt < 200);
        chk("c_second_gap", 64'(cnt), 64'd17);
        chk("c_second_bcd", 64'(bcd_c), 64'h00001);
        chk("c_second_ovf", 64'(ovf_c), 64'd0);
        @(posedge clk); #1;
        chk("c_done_one_cycle", 64'(done_c), 64'd0);
        chk("c_idle_after", 64'(busy_c), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
